// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and operation classifiers for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    mulOp, mulhOp, mulhsuOp, mulhuOp, divOp, divuOp, remOp, remuOp
  } muldiv_op_t;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} muldiv_state_t;

  typedef enum logic [1:0] {noALU, addALU, subALU} alu_op_t;

  function automatic logic op_is_div(muldiv_op_t o);
    return o inside {divOp, divuOp, remOp, remuOp};
  endfunction

  function automatic logic op_is_rem(muldiv_op_t o);
    return o inside {remOp, remuOp};
  endfunction

  function automatic logic op_is_mulhi(muldiv_op_t o);
    return o inside {mulhOp, mulhsuOp, mulhuOp};
  endfunction

  function automatic logic op_signed1(muldiv_op_t o);
    return o inside {mulhOp, mulhsuOp, divOp, remOp};
  endfunction

  function automatic logic op_signed2(muldiv_op_t o);
    return o inside {mulhOp, divOp, remOp};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_alu.sv
// Minimal add/subtract ALU shared by the multiply/divide sequencer.
module muldiv_sequencer_alu
  import muldiv_sequencer_pkg::*;
(
  input  alu_op_t     operation,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    unique case (operation)
      addALU:  y = a + b;
      subALU:  y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle through a single shared add/subtract ALU.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  muldiv_state_t state, state_next;
  muldiv_op_t    op_r;
  logic [31:0]   acc;   // hi (multiply) / partial remainder (divide)
  logic [31:0]   lo;    // multiplier -> lo (multiply) / dividend -> quotient (divide)
  logic [31:0]   opnd;  // multiplicand / divisor magnitude
  logic          sign1, sign2;
  logic [4:0]    cnt;

  alu_op_t       alu_op;
  logic [31:0]   alu_a, alu_b, alu_y;

  logic [31:0]   shifted;
  logic          rem_ge;
  logic          carry;
  logic          special;
  logic [31:0]   spec_val;
  logic [31:0]   fix_src;
  logic          fix_neg;
  logic          s1_now, s2_now;

  muldiv_sequencer_alu u_alu (
    .operation (alu_op),
    .a         (alu_a),
    .b         (alu_b),
    .y         (alu_y)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign shifted = {acc[30:0], lo[31]};
  assign rem_ge  = acc[31] || (shifted >= opnd);
  assign carry   = (alu_y < acc);

  // In PREP, lo/opnd still hold the raw rs1/rs2 captured at start.
  assign s1_now  = op_signed1(op_r) & lo[31];
  assign s2_now  = op_signed2(op_r) & opnd[31];
  assign special = op_is_div(op_r) &&
                   ((opnd == '0) ||
                    ((op_r inside {divOp, remOp}) && (lo == 32'h8000_0000) && (opnd == '1)));
  always_comb begin
    spec_val = '0;
    if (opnd == '0) spec_val = op_is_rem(op_r) ? lo : '1;
    else            spec_val = op_is_rem(op_r) ? '0 : 32'h8000_0000;
  end

  assign fix_src = (op_is_rem(op_r) || op_is_mulhi(op_r)) ? acc : lo;
  assign fix_neg = op_is_rem(op_r) ? sign1 : (sign1 ^ sign2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = noALU;
    alu_a      = '0;
    alu_b      = '0;
    unique case (state)
      IDLE: if (start) state_next = PREP;
      PREP: begin
        alu_op     = subALU;
        alu_b      = lo;
        state_next = special ? DONE : ITER;
      end
      ITER: begin
        if (op_is_div(op_r)) begin
          alu_op = subALU;
          alu_a  = shifted;
          alu_b  = opnd;
        end else if (lo[0]) begin
          alu_op = addALU;
          alu_a  = acc;
          alu_b  = opnd;
        end
        if (cnt == LAST_ITER) state_next = FIX;
      end
      FIX: begin
        state_next = DONE;
        if (fix_neg && !(op_is_mulhi(op_r) && lo != '0)) begin
          alu_op = subALU;
          alu_b  = fix_src;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r   <= mulOp;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_r <= muldiv_op_t'(op);
          lo   <= rs1;
          opnd <= rs2;
        end
        PREP: begin
          // Single ALU: it negates rs1; the rs2 magnitude uses a local two's complement.
          sign1 <= s1_now;
          sign2 <= s2_now;
          acc   <= '0;
          cnt   <= '0;
          if (s1_now) lo   <= alu_y;
          if (s2_now) opnd <= ~opnd + 32'd1;
          if (special) result <= spec_val;
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          if (op_is_div(op_r)) begin
            acc <= rem_ge ? alu_y : shifted;
            lo  <= {lo[30:0], rem_ge};
          end else if (lo[0]) begin
            acc <= {carry, alu_y[31:1]};
            lo  <= {alu_y[0], lo[31:1]};
          end else begin
            acc <= {1'b0, acc[31:1]};
            lo  <= {acc[0], lo[31:1]};
          end
        end
        FIX: begin
          // Negating the high word of a 64-bit product only needs the +1 when lo is zero.
          if (!fix_neg)                              result <= fix_src;
          else if (op_is_mulhi(op_r) && lo != '0)    result <= ~acc;
          else                                       result <= alu_y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: arithmetic/timeline model compared every cycle, plus literal vectors.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  int          m_left = 0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pending = '0;

  muldiv_sequencer #(.XLEN(32), .ITERS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic bit is_special(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    if (!o[2]) return 0;
    if (b == 32'd0) return 1;
    return (o == divOp || o == remOp) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint          sa, sb, ua, ub, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      mulOp:    begin p = ua * ub; return p[31:0]; end
      mulhOp:   begin p = sa * sb; return p[63:32]; end
      mulhsuOp: begin p = sa * ub; return p[63:32]; end
      mulhuOp:  begin up = longint'(ua) * longint'(ub); return up[63:32]; end
      divOp:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_special(o, a, b)) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      divuOp:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      remOp:    begin
        if (b == 0) return a;
        if (is_special(o, a, b)) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timeline model: edges left until idle; done is visible on the last one.
  always @(posedge clk) begin
    if (rst) begin
      m_left   = 0;
      m_result = '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left    = is_special(op, rs1, rs2) ? 2 : 35;
        m_pending = model(op, rs1, rs2);
      end
    end else begin
      m_left--;
      if (m_left == 1) m_result = m_pending;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (busy !== (m_left != 0)) begin
        miscompares++;
        $display("FAIL busy t=%0t got %b want %b", $time, busy, (m_left != 0));
      end
      vectors++;
      if (done !== (m_left == 1)) begin
        miscompares++;
        $display("FAIL done t=%0t got %b want %b", $time, done, (m_left == 1));
      end
      vectors++;
      if (result !== m_result) begin
        miscompares++;
        $display("FAIL result t=%0t got %h want %h", $time, result, m_result);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int want_lat,
                        input bit noise);
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 45 && !seen; j++) begin
      if (done === 1'b1) begin
        seen = 1;
        check({name, "_res"}, result, want);
        check({name, "_lat"}, 32'(j + 1), 32'(want_lat));
      end else begin
        if (noise && (j == 5 || j == 20)) check({name, "_busy_noise"}, {31'd0, busy}, 32'd1);
        if (noise && (j == 4 || j == 19)) begin
          start = 1'b1; op = mulOp; rs1 = 32'd9; rs2 = 32'd9;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_timeout got no done want done within 45 cycles", name);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op("mulhu_ff",  mulhuOp,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0);
    run_op("mul_ff",    mulOp,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 35, 0);
    run_op("mulh_m1x2", mulhOp,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 35, 0);
    run_op("mulhsu",    mulhsuOp, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 35, 0);
    run_op("mulh_min",  mulhOp,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 0);
    run_op("mulh_lo0",  mulhOp,   32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 35, 0);
    run_op("mul_neg",   mulOp,    32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 35, 0);
    run_op("mul_shift", mulOp,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 35, 0);
    run_op("div_m7_2",  divOp,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35, 0);
    run_op("rem_m7_2",  remOp,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35, 0);
    run_op("div_7_m2",  divOp,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0);
    run_op("rem_7_m2",  remOp,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 35, 0);
    run_op("divu_100",  divuOp,   32'd100,       32'd7,         32'd14,        35, 0);
    run_op("remu_100",  remuOp,   32'd100,       32'd7,         32'd2,         35, 0);
    run_op("divu_big",  divuOp,   32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 35, 0);
    run_op("remu_big",  remuOp,   32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 35, 0);
    run_op("divu_z",    divuOp,   32'd5,         32'd0,         32'hFFFF_FFFF, 2,  0);
    run_op("rem_z",     remOp,    32'd5,         32'd0,         32'd5,         2,  0);
    run_op("div_ovf",   divOp,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  0);
    run_op("rem_ovf",   remOp,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,  0);
    run_op("divu_noise", divuOp,  32'd100,       32'd7,         32'd14,        35, 1);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = divOp; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    rst = 1'b0;
    run_op("mul_3x4", mulOp, 32'd3, 32'd4, 32'd12, 35, 0);

    repeat (3) @(negedge clk);
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
